// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control sequencer between IR and the bus-based datapath.
// Fetch / decode / execute microsteps with ready/done handshakes, a bounded
// per-handshake wait counter, stop-at-boundary pause, and sticky trap/fault states.
// Optional build macro SEQ_STEP_EN: pause after every instruction and resume
// only on a step pulse (a step seen while stop=1 is ignored).
//
// state   | meaning
// --------+-----------------------------------------------------------
// RESET   | held in reset / first cycle after reset, con_reset=1
// F0      | PC to bus, load MAR, increment PC
// F1      | memory read into MDR, waits on mem_ready
// F2      | MDR to IR, decode opcode (latched into op_q)
// T0..T4  | execute microsteps of the opcode held in op_q
// PAUSE   | stopped at an instruction boundary
// HALTED  | HALT executed, absorbing
// TRAP    | illegal opcode, absorbing
// FAULT   | handshake timeout, absorbing

module cpu_sequencer #(
  parameter int OPC_W    = 5,
  parameter int IR_W     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IR_W-1:0] ir,
  input  logic            stop,
  input  logic            step,
  input  logic            mem_ready,
  input  logic            alu_done,
  output logic [3:0]      bus_sel,
  output logic [9:0]      ld,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            rin,
  output logic            rout,
  output logic            baout,
  output logic            inc_pc,
  output logic            mem_read,
  output logic            mem_write,
  output logic            br,
  output logic            pc_save,
  output logic            con_reset,
  output logic            run,
  output logic            halted,
  output logic            fault,
  output logic            illegal
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_MAX - 1);

  localparam logic [3:0] BUS_PC = 4'd1, BUS_MDR = 4'd2, BUS_ZLO = 4'd3,
                         BUS_HI = 4'd5, BUS_LO = 4'd6, BUS_C = 4'd7,
                         BUS_IN = 4'd8, BUS_REG = 4'd9;

  localparam int LD_PC = 0, LD_IR = 1, LD_MAR = 2, LD_MDR = 3, LD_Y = 4,
                 LD_Z = 5, LD_HI = 6, LD_LO = 7, LD_CON = 8, LD_OUTP = 9;

  localparam int OP_LD = 0, OP_LDI = 1, OP_ST = 2, OP_ADD = 3, OP_ADDI = 12,
                 OP_ANDI = 13, OP_ORI = 14, OP_DIV = 15, OP_MUL = 16,
                 OP_NEG = 17, OP_NOT = 18, OP_BR = 19, OP_JAL = 20,
                 OP_JR = 21, OP_IN = 22, OP_OUT = 23, OP_MFLO = 24,
                 OP_MFHI = 25, OP_HALT = 27, OP_FIRST_ILLEGAL = 28;

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_PAUSE, S_HALTED, S_TRAP, S_FAULT
  } state_t;

  state_t           state, state_nx;
  logic [OPC_W-1:0] op_q, op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [OPC_W-1:0] opc_in;
  logic [31:0]      opc_in_ext, op_ext;
  logic             is_mem, is_alu, is_imm, is_muldiv, hs_ready;
  state_t           last_st, wait_st, bnd_nx;
  logic             unused_bits;

  assign opc_in     = ir[IR_W-1 -: OPC_W];
  assign opc_in_ext = 32'(opc_in);
  assign op_ext     = 32'(op_q);
  // register fields are decoded by the external select/encode logic
  assign unused_bits = ^{step, ir[IR_W-OPC_W-1:0]};

  assign is_mem    = (op_ext <= OP_ST);
  assign is_alu    = (op_ext >= OP_ADD && op_ext <= OP_ORI) ||
                     op_ext == OP_NEG || op_ext == OP_NOT;
  assign is_imm    = (op_ext >= OP_ADDI && op_ext <= OP_ORI);
  assign is_muldiv = (op_ext == OP_DIV || op_ext == OP_MUL);
  assign hs_ready  = is_muldiv ? alu_done : mem_ready;

  function automatic logic [3:0] alu_code(input logic [31:0] op);
    logic [3:0] c;
    c = 4'd0;
    if (op >= 32'd3 && op <= 32'd11) c = 4'(op - 32'd3);
    else if (op == OP_ANDI)          c = 4'd2;
    else if (op == OP_ORI)           c = 4'd3;
    else if (op == OP_DIV)           c = 4'd10;
    else if (op == OP_MUL)           c = 4'd9;
    else if (op == OP_NEG)           c = 4'd11;
    else if (op == OP_NOT)           c = 4'd12;
    return c;
  endfunction

  // last microstep and handshake microstep of the current opcode
  always_comb begin
    last_st = S_T0;
    wait_st = S_F1;
    if (op_ext == OP_LD || op_ext == OP_ST) last_st = S_T4;
    else if (is_muldiv)                     last_st = S_T3;
    else if (is_alu || op_ext == OP_LDI || op_ext == OP_BR) last_st = S_T2;
    else if (op_ext == OP_JAL)              last_st = S_T1;
    if (op_ext == OP_LD)      wait_st = S_T3;
    else if (op_ext == OP_ST) wait_st = S_T4;
    else if (is_muldiv)       wait_st = S_T2;
`ifdef SEQ_STEP_EN
    bnd_nx = S_PAUSE;
`else
    bnd_nx = stop ? S_PAUSE : S_F0;
`endif
  end

  // state, latched opcode and wait counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
    end
  end

  // next-state logic; the counter only survives a cycle that stalls in a wait step
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    cnt_nx   = '0;
    case (state)
      S_RESET: state_nx = S_F0;
      S_F0:    state_nx = S_F1;
      S_F1: begin
        if (mem_ready)           state_nx = S_F2;
        else if (cnt == CNT_LIM) state_nx = S_FAULT;
        else                     cnt_nx = cnt + 1'b1;
      end
      S_F2: begin
        op_nx = opc_in;
        if (opc_in_ext >= OP_FIRST_ILLEGAL) state_nx = S_TRAP;
        else if (opc_in_ext == OP_HALT)     state_nx = S_HALTED;
        else                                state_nx = S_T0;
      end
      S_T0, S_T1, S_T2, S_T3, S_T4: begin
        if (state == wait_st && !hs_ready) begin
          if (cnt == CNT_LIM) state_nx = S_FAULT;
          else                cnt_nx = cnt + 1'b1;
        end else if (state == last_st) begin
          state_nx = bnd_nx;
        end else begin
          case (state)
            S_T0:    state_nx = S_T1;
            S_T1:    state_nx = S_T2;
            S_T2:    state_nx = S_T3;
            default: state_nx = S_T4;
          endcase
        end
      end
      S_PAUSE: begin
`ifdef SEQ_STEP_EN
        if (step && !stop) state_nx = S_F0;
`else
        if (!stop) state_nx = S_F0;
`endif
      end
      S_HALTED, S_TRAP, S_FAULT: state_nx = state;
      default: state_nx = S_RESET;
    endcase
  end

  // Moore outputs decoded from state and latched opcode
  always_comb begin
    bus_sel   = 4'd0;
    ld        = 10'd0;
    alu_op    = 4'd0;
    alu_start = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    rin = 1'b0; rout = 1'b0; baout = 1'b0;
    inc_pc = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    br = 1'b0; pc_save = 1'b0; con_reset = 1'b0;
    halted = 1'b0; fault = 1'b0; illegal = 1'b0;
    run = (state == S_F0 || state == S_F1 || state == S_F2 || state == S_T0 ||
           state == S_T1 || state == S_T2 || state == S_T3 || state == S_T4);
    case (state)
      S_RESET: con_reset = 1'b1;
      S_F0: begin
        bus_sel = BUS_PC; ld[LD_PC] = 1'b1; ld[LD_MAR] = 1'b1; inc_pc = 1'b1;
      end
      S_F1: begin
        mem_read = 1'b1; ld[LD_MDR] = 1'b1;
      end
      S_F2: begin
        bus_sel = BUS_MDR; ld[LD_IR] = 1'b1;
      end
      S_HALTED: halted = 1'b1;
      S_TRAP:   begin illegal = 1'b1; halted = 1'b1; end
      S_FAULT:  begin fault = 1'b1; halted = 1'b1; end
      S_T0, S_T1, S_T2, S_T3, S_T4: begin
        if (is_mem) begin
          case (state)
            S_T0: begin bus_sel = BUS_REG; grb = 1'b1; baout = 1'b1; ld[LD_Y] = 1'b1; end
            S_T1: begin bus_sel = BUS_C; ld[LD_Z] = 1'b1; end
            S_T2: begin
              bus_sel = BUS_ZLO;
              if (op_ext == OP_LDI) begin gra = 1'b1; rin = 1'b1; end
              else ld[LD_MAR] = 1'b1;
            end
            S_T3: begin
              ld[LD_MDR] = 1'b1;
              if (op_ext == OP_LD) mem_read = 1'b1;
              else begin bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; end
            end
            default: begin
              if (op_ext == OP_LD) begin bus_sel = BUS_MDR; gra = 1'b1; rin = 1'b1; end
              else mem_write = 1'b1;
            end
          endcase
        end else if (is_alu) begin
          case (state)
            S_T0: begin bus_sel = BUS_REG; grb = 1'b1; rout = 1'b1; ld[LD_Y] = 1'b1; end
            S_T1: begin
              alu_op = alu_code(op_ext); ld[LD_Z] = 1'b1;
              if (is_imm) bus_sel = BUS_C;
              else begin
                bus_sel = BUS_REG; rout = 1'b1;
                if (op_ext == OP_NEG || op_ext == OP_NOT) grb = 1'b1;
                else grc = 1'b1;
              end
            end
            default: begin bus_sel = BUS_ZLO; gra = 1'b1; rin = 1'b1; end
          endcase
        end else if (is_muldiv) begin
          case (state)
            S_T0: begin bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; ld[LD_Y] = 1'b1; end
            S_T1: begin
              bus_sel = BUS_REG; grb = 1'b1; rout = 1'b1;
              alu_op = alu_code(op_ext); alu_start = 1'b1;
            end
            S_T2: alu_op = alu_code(op_ext);
            default: begin ld[LD_HI] = 1'b1; ld[LD_LO] = 1'b1; end
          endcase
        end else if (op_ext == OP_BR) begin
          case (state)
            S_T0: begin bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; ld[LD_CON] = 1'b1; end
            S_T1: begin inc_pc = 1'b1; ld[LD_PC] = 1'b1; br = 1'b1; end
            default: con_reset = 1'b1;
          endcase
        end else if (op_ext == OP_JAL) begin
          if (state == S_T0) begin
            pc_save = 1'b1; bus_sel = BUS_PC; gra = 1'b1; rin = 1'b1;
          end else begin
            bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; ld[LD_PC] = 1'b1;
          end
        end else if (state == S_T0) begin
          case (op_ext)
            OP_JR:   begin bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; ld[LD_PC] = 1'b1; end
            OP_IN:   begin bus_sel = BUS_IN; gra = 1'b1; rin = 1'b1; end
            OP_OUT:  begin bus_sel = BUS_REG; gra = 1'b1; rout = 1'b1; ld[LD_OUTP] = 1'b1; end
            OP_MFLO: begin bus_sel = BUS_LO; gra = 1'b1; rin = 1'b1; end
            OP_MFHI: begin bus_sel = BUS_HI; gra = 1'b1; rin = 1'b1; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule
